// File: rtl/secret_arbiter.sv
// secret_arbiter: round-robin arbiter that time-shares one accumulate-and-select
// engine among N_REQ requesters, each with a private accumulator context.
// A grant in IDLE produces one tagged response; the block then waits in RESP
// until the sink takes it.
// Optional build macro: SECRET_ARBITER_STATS_EN adds the grant_cnt output.
module secret_arbiter #(
  parameter int N_REQ  = 2,
  parameter int WIDTH  = 32,
  parameter int THRESH = 10,
  parameter int SECRET = 9,
  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       acc_clr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_x,
  output logic [ID_W-1:0]        rsp_id
`ifdef SECRET_ARBITER_STATS_EN
  ,
  output logic [15:0]            grant_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_x_q, rsp_x_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] acc_q [N_REQ];
  logic [WIDTH-1:0] acc_d [N_REQ];
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [ID_W-1:0]  grant;
  logic             grant_vld;
  logic             accept;

  // Unpack the flat operand buses into per-requester words.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: first valid requester after the last grant, with wrap.
  // Scanning from the farthest candidate down lets the nearest one win.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        grant     = ID_W'((int'(ptr_q) + k) % N_REQ);
        grant_vld = 1'b1;
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_vld;

  // One-hot accept strobe; forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept) begin
      req_ready[grant] = 1'b1;
    end
  end

  // FSM next state and response capture; compare uses the pre-update accumulator.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_x_d     = rsp_x_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          if (acc_q[grant] > WIDTH'(THRESH)) begin
            rsp_x_d = b_arr[grant];
          end else begin
            rsp_x_d = a_arr[grant] + b_arr[grant] + WIDTH'(SECRET);
          end
          rsp_id_d    = grant;
          ptr_d       = grant;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // Accumulator update; a coincident clear overrides the accumulate.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      acc_d[i] = acc_q[i];
      if (accept && (grant == ID_W'(i))) begin
        acc_d[i] = acc_q[i] + a_arr[i];
      end
      if (acc_clr[i]) begin
        acc_d[i] = '0;
      end
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Per-requester accumulator contexts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_id    = rsp_id_q;

`ifdef SECRET_ARBITER_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating accept counter; clearing every context at once also clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (&acc_clr) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_secret_arbiter.sv
// Bench for secret_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model of the arbiter.
module tb_secret_arbiter;
  localparam int N   = 2;
  localparam int W   = 32;
  localparam int TH  = 10;
  localparam int SC  = 9;
  localparam int IDW = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     acc_clr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_x;
  logic [IDW-1:0]   rsp_id;
`ifdef SECRET_ARBITER_STATS_EN
  logic [15:0]      grant_cnt;
`endif

  always #5 clk = ~clk;

  secret_arbiter #(.N_REQ(N), .WIDTH(W), .THRESH(TH), .SECRET(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .acc_clr   (acc_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_id    (rsp_id)
`ifdef SECRET_ARBITER_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (transaction level).
  logic [W-1:0] m_acc [N];
  int           m_ptr;
  bit           m_busy;
  logic [W-1:0] m_x;
  int           m_id;
`ifdef SECRET_ARBITER_STATS_EN
  int           m_cnt;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_acc[i] = '0;
    m_ptr  = N - 1;
    m_busy = 1'b0;
    m_x    = '0;
    m_id   = 0;
`ifdef SECRET_ARBITER_STATS_EN
    m_cnt  = 0;
`endif
  endtask

  // Next requester to win, or -1: nearest valid one after the last grant.
  function automatic int model_grant();
    if (m_busy) return -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step(output int g);
    logic [N-1:0] exp_rdy;
    logic [W-1:0] va, vb;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_busy && rsp_ready) m_busy = 1'b0;
    if (g >= 0) begin
      va = req_a[g*W +: W];
      vb = req_b[g*W +: W];
      if (m_acc[g] > TH) m_x = vb;
      else               m_x = va + vb + SC;
      m_acc[g] = m_acc[g] + va;
      m_id     = g;
      m_ptr    = g;
      m_busy   = 1'b1;
`ifdef SECRET_ARBITER_STATS_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end
    for (int i = 0; i < N; i++) if (acc_clr[i]) m_acc[i] = '0;
`ifdef SECRET_ARBITER_STATS_EN
    if (&acc_clr) m_cnt = 0;
`endif
    @(posedge clk);
    #1;
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_busy));
    if (m_busy) begin
      check_val("rsp_x", rsp_x, m_x);
      check_val("rsp_id", 32'(rsp_id), 32'(m_id));
    end
`ifdef SECRET_ARBITER_STATS_EN
    check_val("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic idle_step(input logic [N-1:0] clr);
    int g;
    req_valid = '0;
    acc_clr   = clr;
    rsp_ready = 1'b1;
    step(g);
    acc_clr   = '0;
  endtask

  // Single-requester transaction with immediate sink acceptance.
  task automatic xact(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [N-1:0] clr, output logic [W-1:0] x, output int id);
    int g;
    req_valid      = '0;
    req_valid[i]   = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    acc_clr        = clr;
    rsp_ready      = 1'b1;
    step(g);
    x  = rsp_x;
    id = int'(rsp_id);
    req_valid = '0;
    acc_clr   = '0;
    step(g);
  endtask

  logic [W-1:0] x;
  int           id;
  int           g;
  bit           pend [N];
  logic [W-1:0] exp_seq [4];
  logic [W-1:0] a_seq [4];
  logic [W-1:0] b_seq [4];

  initial begin
    rst_n     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    acc_clr   = '0;
    rsp_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_x", rsp_x, 32'd0);
    check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef SECRET_ARBITER_STATS_EN
    check_val("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters continuously valid: grants alternate starting at 0.
    req_valid = '1;
    req_a     = '0;
    for (int i = 0; i < N; i++) req_b[i*W +: W] = 32'd1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(g);
      check_val("alt_valid", 32'(rsp_valid), 32'((k % 2) == 0));
      if ((k % 2) == 0) check_val("alt_id", 32'(rsp_id), 32'((k / 2) % 2));
    end
    req_valid = '0;
    idle_step('0);

    // Requester 0 sequence crossing the threshold.
    a_seq = '{32'd3, 32'd5, 32'd3, 32'd1};
    b_seq = '{32'd4, 32'd4, 32'd4, 32'd7};
    exp_seq = '{32'd16, 32'd18, 32'd16, 32'd7};
    for (int k = 0; k < 4; k++) begin
      xact(0, a_seq[k], b_seq[k], '0, x, id);
      check_val("seq_x", x, exp_seq[k]);
      check_val("seq_id", 32'(id), 32'd0);
    end

    // Backpressure: response must hold while the sink stalls.
    idle_step('1);
    req_valid = 2'b01;
    req_a[0 +: W] = 32'd3;
    req_b[0 +: W] = 32'd4;
    rsp_ready = 1'b0;
    step(g);
    req_valid = 2'b10;
    req_a[W +: W] = 32'd5;
    req_b[W +: W] = 32'd4;
    for (int k = 0; k < 5; k++) begin
      step(g);
      check_val("bp_valid", 32'(rsp_valid), 32'd1);
      check_val("bp_x", rsp_x, 32'd16);
      check_val("bp_id", 32'(rsp_id), 32'd0);
      check_val("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step(g);
    step(g);
    check_val("bp_next_id", 32'(rsp_id), 32'd1);
    check_val("bp_next_x", rsp_x, 32'd18);
    req_valid = '0;
    step(g);

    // Accumulator wrap on requester 1.
    idle_step(2'b10);
    xact(1, 32'hFFFF_FFFF, 32'd0, '0, x, id);
    check_val("wrap_x0", x, 32'd8);
    xact(1, 32'd2, 32'd0, '0, x, id);
    check_val("wrap_x1", x, 32'd0);
    xact(1, 32'd1, 32'd2, '0, x, id);
    check_val("wrap_x2", x, 32'd12);
    check_val("wrap_id", 32'(id), 32'd1);

    // Clear coinciding with a grant: old value used, clear wins.
    idle_step(2'b01);
    xact(0, 32'd11, 32'd0, '0, x, id);
    check_val("clr_setup_x", x, 32'd20);
    xact(0, 32'd1, 32'd5, 2'b01, x, id);
    check_val("clr_x", x, 32'd5);
    xact(0, 32'd1, 32'd1, '0, x, id);
    check_val("clr_after_x", x, 32'd11);

    // Randomized traffic with held operands, drops, clears and stalls.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            req_b[i*W +: W] = W'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
        req_valid[i] = pend[i];
        acc_clr[i]   = ($urandom_range(0, 19) == 0);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle_step('0);

    // Reset while a response is pending.
    req_valid = 2'b01;
    req_a[0 +: W] = 32'd3;
    req_b[0 +: W] = 32'd4;
    rsp_ready = 1'b0;
    step(g);
    check_val("mid_valid_before", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_valid_rst", 32'(rsp_valid), 32'd0);
    check_val("mid_ready_rst", 32'(req_ready), 32'd0);
`ifdef SECRET_ARBITER_STATS_EN
    check_val("mid_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    model_reset();
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'd1;
      req_b[i*W +: W] = 32'd2;
    end
    rsp_ready = 1'b1;
    step(g);
    check_val("post_rst_id", 32'(rsp_id), 32'd0);
    check_val("post_rst_x", rsp_x, 32'd12);
    req_valid = '0;
    step(g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/secret_arbiter.md
Name: secret_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one protected accumulate-and-select engine among N_REQ requesters.
- Each requester owns a private accumulator context held inside the block.
- Requests enter on per-requester valid/ready ports; results leave on one tagged valid/ready response port.
- Sits between client logic and the secret datapath; ships as a protected library alongside the engine.

Parameters:
- N_REQ, 2, number of requesters (legal range 2..8).
- WIDTH, 32, width of operands, accumulators and result.
- THRESH, 10, accumulator compare threshold (unsigned).
- SECRET, 9, constant added on the below-threshold path.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_a  input  N_REQ*WIDTH  operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand b; same slicing as req_a.
- req_ready  output  N_REQ  one-hot-or-zero accept strobe.
- acc_clr  input  N_REQ  synchronous per-requester accumulator clear.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by sink.
- rsp_x  output  WIDTH  result.
- rsp_id  output  max(1,$clog2(N_REQ))  index of requester that produced rsp_x.

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces:
  - state=IDLE, rsp_valid=0, rsp_x=0, rsp_id=0;
  - all accumulators=0;
  - last-grant pointer=N_REQ-1, so requester 0 has first priority.
  - req_ready is combinational and is 0 while rst_n is low.
- FSM has two states, IDLE and RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching from (pointer+1) mod N_REQ upward with wrap.
  - Drive req_ready[g]=1 combinationally that cycle; every other req_ready bit is 0.
  - On that clock edge:
    - rsp_x <= (acc[g] > THRESH) ? req_b[g] : req_a[g]+req_b[g]+SECRET;
    - acc[g] <= acc[g]+req_a[g];
    - rsp_id <= g; pointer <= g; rsp_valid <= 1; state <= RESP.
  - With no req_valid set, state stays IDLE and the pointer is unchanged.
- RESP:
  - req_ready is all 0.
  - rsp_valid, rsp_x and rsp_id hold stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid <= 0, state <= IDLE.
- Latency: accept at edge T gives rsp_valid high from T+1. Peak throughput is one transaction per 2 cycles.
- Arithmetic:
  - All sums wrap modulo 2^WIDTH.
  - The compare uses the pre-update accumulator value and is unsigned.
- acc_clr[i] sets acc[i] to 0 at the next edge, in any state.
  - If acc_clr[g] coincides with the grant of g: rsp_x is computed from the old acc[g], and the clear wins, so acc[g] becomes 0.
- A requester must hold req_valid, req_a and req_b stable until it sees req_ready. Dropping req_valid before grant is permitted (no accept occurs).
- Reset asserted mid-RESP discards the pending response. Accumulators and pointer return to reset values immediately.

Optional Feature:
- Macro SECRET_ARBITER_STATS_EN.
- When defined, adds output port grant_cnt (16 bits):
  - counts accepted requests across all requesters;
  - saturates at 0xFFFF;
  - reset value 0;
  - cleared to 0 when all acc_clr bits are high in the same cycle.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Single requester 0, rsp_ready=1, requests (a,b) = (3,4), (5,4), (3,4), (1,7):
  - rsp_x = 16, 18, 16, 7;
  - acc[0] = 3, 8, 11, 12;
  - rsp_id=0 each time.
- Requesters 0 and 1 both continuously valid, rsp_ready=1:
  - grants alternate 0,1,0,1;
  - rsp_valid pulses every 2nd cycle;
  - rsp_id matches the grant;
  - first grant goes to 0 after reset.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with rsp_x=16:
  - rsp_valid, rsp_x and rsp_id stay constant;
  - req_ready stays 0;
  - the cycle after rsp_ready=1, state is IDLE and the next grant proceeds.
- Wrap: drive acc[1] to 0xFFFFFFFF via a=0xFFFFFFFF, then a=2:
  - acc[1]=1;
  - next request (a=1, b=2) gives rsp_x=12.
- Simultaneous clear: acc[0]=11, grant 0 with a=1, b=5 and acc_clr[0]=1 in the same cycle:
  - rsp_x=5;
  - acc[0]=0;
  - next request (a=1, b=1) gives rsp_x=11.
- Reset mid-RESP: drop rst_n while rsp_valid=1:
  - rsp_valid goes 0 immediately;
  - after release, the first grant goes to requester 0 with acc=0.
  - With SECRET_ARBITER_STATS_EN defined, grant_cnt reads 0.
